// File: rtl/vga_console_ctrl.sv
// rtl/vga_console_ctrl.sv - byte-stream text console write sequencer for the VGA character buffer
//
// Purpose: accepts bytes over a valid/ready handshake, keeps a text cursor, interprets
// CR/LF/BS and drives one character-buffer write per cycle. Also runs a full-screen
// clear (0x20 fill) on request.
//
// Optional feature: define VGA_CONSOLE_LINE_CLEAR_EN to blank the new row (LCLR state)
// after every row advance. Without it a row advance is a zero-cycle cursor update.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   char_valid_i/char_i  offered byte; char_ready_o high when it can be taken
//   clear_i              clear-screen request (level, sampled each cycle)
//   busy_o               clear / line-clear in progress or pending
//   cursor_x_o/_y_o      current cursor column / row
//   vga_char_o/addr_o/wen_o  registered character-buffer write port
module vga_console_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int ADDR_W = $clog2(COLS*ROWS)
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      char_valid_i,
    input  logic [7:0]                char_i,
    output logic                      char_ready_o,
    input  logic                      clear_i,
    output logic                      busy_o,
    output logic [$clog2(COLS)-1:0]   cursor_x_o,
    output logic [$clog2(ROWS)-1:0]   cursor_y_o,
    output logic [7:0]                vga_char_o,
    output logic [ADDR_W-1:0]         vga_addr_o,
    output logic                      vga_wen_o
);

    localparam int X_W = $clog2(COLS);
    localparam int Y_W = $clog2(ROWS);
    localparam logic [X_W-1:0]    X_MAX     = X_W'(COLS - 1);
    localparam logic [Y_W-1:0]    Y_MAX     = Y_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS*ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
    localparam logic [7:0]        SPACE     = 8'h20;

`ifdef VGA_CONSOLE_LINE_CLEAR_EN
    typedef enum logic [1:0] {IDLE, CLEAR, LCLR} state_t;
    logic [X_W-1:0] lclr_cnt;
`else
    typedef enum logic [1:0] {IDLE, CLEAR} state_t;
`endif

    state_t            state;
    logic              clr_pend;
    logic [ADDR_W-1:0] row_base;   // always equals cursor_y_o * COLS
    logic              accept;

    // Next-cursor and write decode for the byte currently offered.
    logic [X_W-1:0]    nx_x;
    logic [Y_W-1:0]    nx_y;
    logic [ADDR_W-1:0] nx_rb;
    logic              adv;
    logic              wr;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_char;

    assign char_ready_o = (state == IDLE) & ~clr_pend & ~clear_i;
    assign busy_o       = (state != IDLE) | clr_pend;
    assign accept       = char_valid_i & char_ready_o;
    assign cur_addr     = row_base + ADDR_W'(cursor_x_o);

    always_comb begin
        nx_x    = cursor_x_o;
        nx_y    = cursor_y_o;
        nx_rb   = row_base;
        adv     = 1'b0;
        wr      = 1'b0;
        wr_addr = cur_addr;
        wr_char = char_i;
        if (char_i >= 8'h20 && char_i <= 8'h7E) begin
            wr = 1'b1;
            if (cursor_x_o == X_MAX) begin
                nx_x = '0;
                adv  = 1'b1;
            end else begin
                nx_x = cursor_x_o + 1'b1;
            end
        end else if (char_i == 8'h0A) begin
            nx_x = '0;
            adv  = 1'b1;
        end else if (char_i == 8'h0D) begin
            nx_x = '0;
        end else if (char_i == 8'h08 && cursor_x_o != '0) begin
            nx_x    = cursor_x_o - 1'b1;
            wr      = 1'b1;
            wr_addr = cur_addr - 1'b1;
            wr_char = SPACE;
        end
        // Row advance wraps to the top; there is no scrolling.
        if (adv) begin
            if (cursor_y_o == Y_MAX) begin
                nx_y  = '0;
                nx_rb = '0;
            end else begin
                nx_y  = cursor_y_o + 1'b1;
                nx_rb = row_base + ROW_STEP;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            clr_pend   <= 1'b0;
            row_base   <= '0;
            cursor_x_o <= '0;
            cursor_y_o <= '0;
            vga_char_o <= '0;
            vga_addr_o <= '0;
            vga_wen_o  <= 1'b0;
`ifdef VGA_CONSOLE_LINE_CLEAR_EN
            lclr_cnt   <= '0;
`endif
        end else begin
            vga_wen_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_pend) begin
                        // First fill write goes out on the entry edge.
                        state      <= CLEAR;
                        clr_pend   <= 1'b0;
                        vga_wen_o  <= 1'b1;
                        vga_addr_o <= '0;
                        vga_char_o <= SPACE;
                    end else begin
                        if (clear_i) begin
                            clr_pend <= 1'b1;
                        end
                        if (accept) begin
                            cursor_x_o <= nx_x;
                            cursor_y_o <= nx_y;
                            row_base   <= nx_rb;
                            if (wr) begin
                                vga_wen_o  <= 1'b1;
                                vga_addr_o <= wr_addr;
                                vga_char_o <= wr_char;
                            end
`ifdef VGA_CONSOLE_LINE_CLEAR_EN
                            if (adv) begin
                                state    <= LCLR;
                                lclr_cnt <= '0;
                            end
`endif
                        end
                    end
                end
                CLEAR: begin
                    // vga_addr_o doubles as the fill counter.
                    if (vga_addr_o == LAST_ADDR) begin
                        state      <= IDLE;
                        cursor_x_o <= '0;
                        cursor_y_o <= '0;
                        row_base   <= '0;
                    end else begin
                        vga_wen_o  <= 1'b1;
                        vga_addr_o <= vga_addr_o + 1'b1;
                        vga_char_o <= SPACE;
                    end
                end
`ifdef VGA_CONSOLE_LINE_CLEAR_EN
                LCLR: begin
                    if (clear_i) begin
                        clr_pend <= 1'b1;
                    end
                    // row_base already points at the new row.
                    vga_wen_o  <= 1'b1;
                    vga_addr_o <= row_base + ADDR_W'(lclr_cnt);
                    vga_char_o <= SPACE;
                    if (lclr_cnt == X_MAX) begin
                        state <= IDLE;
                    end else begin
                        lclr_cnt <= lclr_cnt + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
